// File: rtl/piso_serializer_p.sv
// rtl/piso_serializer_p.sv - parametrised parallel-in/serial-out serializer with valid/ready input
//
// Optional feature macro: PISO_PARITY_EN (appends an even-parity bit to each frame)
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   in_valid       source presents a word on in_data
//   in_data        parallel word, captured on accept (in_valid && in_ready)
//   in_ready       block can accept a word this cycle
//   serial_o       serial data line (IDLE_LEVEL when no bit is sent)
//   serial_valid_o serial_o carries a frame bit this cycle
//   last_o         current bit is the final bit of the frame
//   busy_o         frame in progress
module piso_serializer_p #(
    parameter int DATA_W     = 8,
    parameter bit MSB_FIRST  = 1'b0,
    parameter bit IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              serial_o,
    output logic              serial_valid_o,
    output logic              last_o,
    output logic              busy_o
);

    localparam int CW = $clog2(DATA_W + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]     count_q, count_d;
`ifdef PISO_PARITY_EN
    logic              par_q, par_d;
`endif

    logic final_bit;
    logic data_bit;
    logic accept;

    // Output decode depends on registered state only, so in_valid never
    // reaches any output combinationally.
`ifdef PISO_PARITY_EN
    assign final_bit = (state_q == PAR);
`else
    assign final_bit = (state_q == SHIFT) && (count_q == CNT_ONE);
`endif

    assign data_bit       = MSB_FIRST ? sreg_q[DATA_W-1] : sreg_q[0];
    assign busy_o         = (state_q != IDLE);
    assign serial_valid_o = busy_o;
    assign last_o         = final_bit;
    // Ready during the final bit lets a new word reload with no idle gap.
    assign in_ready       = (state_q == IDLE) || final_bit;
    assign accept         = in_valid && in_ready;

    always_comb begin
        serial_o = IDLE_LEVEL;
        case (state_q)
            SHIFT:   serial_o = data_bit;
`ifdef PISO_PARITY_EN
            PAR:     serial_o = par_q;
`endif
            default: serial_o = IDLE_LEVEL;
        endcase
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        count_d = count_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sreg_d  = in_data;
                    count_d = CNT_FULL;
`ifdef PISO_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            SHIFT: begin
                if (count_q > CNT_ONE) begin
                    sreg_d  = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
                    count_d = count_q - CNT_ONE;
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = PAR;
                    sreg_d  = '0;
                    count_d = '0;
`else
                    if (accept) begin
                        sreg_d  = in_data;
                        count_d = CNT_FULL;
                    end else begin
                        state_d = IDLE;
                        sreg_d  = '0;
                        count_d = '0;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PAR: begin
                if (accept) begin
                    state_d = SHIFT;
                    sreg_d  = in_data;
                    count_d = CNT_FULL;
                    par_d   = ^in_data;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                sreg_d  = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            count_q <= '0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            count_q <= count_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: doc/piso_serializer_p.md
Name: piso_serializer_p

Overview:
- Parametrised parallel-in/serial-out serializer; next generation of the byte PISO used on the team's serial transmit paths.
- Adds generic data width, selectable bit order, programmable idle line level, and a valid/ready input handshake.
- Supports zero-gap back-to-back frames.
- Sits between a word-producing source (FIFO or register bank) and a single-wire serial sink.

Parameters:
- DATA_W, 8, word width in bits; legal range 2..64.
- MSB_FIRST, 0, 0 = bit 0 sent first; 1 = bit DATA_W-1 sent first.
- IDLE_LEVEL, 1, value driven on serial_o whenever no bit is being sent.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  source has a word on in_data.
- in_data  input  DATA_W  parallel word; sampled only on an accept.
- in_ready  output  1  block can accept a word this cycle.
- serial_o  output  1  serial data line.
- serial_valid_o  output  1  serial_o carries a frame bit this cycle.
- last_o  output  1  current bit is the final bit of the frame.
- busy_o  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset: rst sampled high at an edge gives the following after that edge:
  - state = IDLE, shift register = 0, count = 0.
  - serial_o = IDLE_LEVEL; serial_valid_o = 0, last_o = 0, busy_o = 0; in_ready = 1.
- Reset mid-frame aborts the frame with no further bits. Reset takes priority over an accept in the same cycle.
- Accept: an accept is in_valid && in_ready at a rising edge. in_data is captured into the shift register and count loads DATA_W.
- States:
  - IDLE -> SHIFT on accept.
  - In SHIFT, when count > 1, shift toward the output end and decrement count.
  - In SHIFT, when count == 1 and an accept occurs, reload the shift register and count and stay in SHIFT (no idle gap).
  - In SHIFT, when count == 1 and no accept occurs, go to IDLE.
  - With PARITY_EN defined, the count == 1 condition moves to the PAR state (see Optional Feature).
- Shift direction:
  - MSB_FIRST = 0: serial_o = sreg[0]; shift right.
  - MSB_FIRST = 1: serial_o = sreg[DATA_W-1]; shift left.
  - Vacated bit positions fill with 0.
- Latency: the first bit appears on serial_o in the cycle immediately after the accept edge. Each bit is held for exactly one clk cycle. A frame occupies DATA_W consecutive cycles.
- serial_valid_o = 1 exactly in SHIFT (and PAR). Otherwise serial_o = IDLE_LEVEL.
- in_ready:
  - 1 in IDLE.
  - 1 during the final frame bit (last_o = 1).
  - 0 otherwise.
  - Combinational from state/count only; never from in_valid.
- last_o = 1 only in the final bit cycle of each frame.
- Back-to-back frames: with in_valid held high, serial_valid_o stays 1 continuously and last_o pulses every DATA_W cycles.
- in_valid while in_ready = 0 is not an accept. The source must hold in_data stable until accepted.
- The count register is $clog2(DATA_W+2) bits wide; no wrap-around is possible.
- serial_o, serial_valid_o, last_o, in_ready and busy_o are decoded from registers only; there is no input-to-output combinational path.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - An extra PAR state follows the final data bit, so a frame is DATA_W+1 cycles.
  - serial_o in PAR = even parity (XOR) of the accepted word, captured at accept.
  - In SHIFT, at count == 1 the block moves to PAR with in_ready = 0 and last_o = 0.
  - last_o and in_ready are asserted in the PAR cycle instead.
  - Back-to-back reload occurs from PAR.
- Undefined: no PAR state, no parity register; behaviour exactly as above.

Test Plan:
1. Reset, DATA_W = 8, MSB_FIRST = 0: accept 8'hA5 one cycle -> serial_o = 1,0,1,0,0,1,0,1 over 8 cycles, last_o on cycle 8, then IDLE with serial_o = 1 and in_ready = 1.
2. MSB_FIRST = 1, accept 8'hA5 -> serial_o = 1,0,1,0,0,1,0,1 starting from bit 7; same timing as 1.
3. in_valid held high with words 8'hFF then 8'h00 -> serial_valid_o stays 1 for 16 cycles, 8 ones then 8 zeros; in_ready high only on cycles 8 and 16.
4. in_valid asserted mid-frame (cycle 3) with 8'h3C -> no capture; word accepted on the last_o cycle; no corruption of the first frame.
5. rst asserted on cycle 4 of a frame -> the next cycle gives serial_o = IDLE_LEVEL, serial_valid_o = 0, busy_o = 0, in_ready = 1; a fresh 8'h81 accept then serializes correctly.
6. PISO_PARITY_EN defined, accept 8'h07 -> 8 data bits, then parity bit = 1 on cycle 9 with last_o = 1; a back-to-back accept on cycle 9 starts the next frame on cycle 10.
